// File: rtl/fifo_wr_gen_pkg.sv
// Shared definitions for the FIFO burst write generator: FSM encoding,
// default data width and the common counter width.
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RDY = 2'd1,
    ST_WRITE    = 2'd2,
    ST_GAP      = 2'd3
  } state_t;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W      = 16;

endpackage

// File: rtl/fifo_wr_gen_gap_timer.sv
// Loadable down-counter; o_done is high while the count sits at zero.
module gap_timer
  import fifo_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk_50M,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_done
);

  localparam logic [W-1:0] ZERO = W'(0);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] r_cnt;

  // count register: load has priority, decrement saturates at zero
  always_ff @(posedge clk_50M) begin
    if (!reset_n) begin
      r_cnt <= ZERO;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != ZERO)) begin
      r_cnt <= r_cnt - ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_done = (r_cnt == ZERO);

endmodule

// File: rtl/fifo_wr_gen.sv
// Burst write generator for the FIFO write port: incrementing data in
// fixed-length bursts, optional continuous mode with idle gaps.
module fifo_wr_gen
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_LEN = 256,
  parameter int GAP_CYC   = 16
) (
  input  logic              clk_50M,
  input  logic              reset_n,
  input  logic              start,
  input  logic              cont,
  input  logic              stop,
  input  logic              fifo_full,
  input  logic              fifo_wr_rst_busy,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_din,
  output logic              busy,
  output logic              burst_done,
  output logic [15:0]       burst_cnt
);

  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [DATA_W-1:0] DIN_ONE  = DATA_W'(1);

  state_t            r_state;
  state_t            w_next;
  logic              r_cont_q;
  logic [CNT_W-1:0]  r_word_cnt;
  logic [DATA_W-1:0] r_din;
  logic              r_busy;
  logic              r_done;
  logic [15:0]       r_burst_cnt;
  logic              w_wr_acc;
  logic              w_last_acc;
  logic              w_gap_done;

  assign w_wr_acc   = (r_state == ST_WRITE) && !fifo_full && !fifo_wr_rst_busy;
  assign w_last_acc = w_wr_acc && (r_word_cnt == LAST_IDX);

  // Held loaded outside GAP so the count starts fresh on every gap entry.
  gap_timer #(.W(CNT_W)) u_gap_timer (
    .clk_50M    (clk_50M),
    .reset_n    (reset_n),
    .i_load     (r_state != ST_GAP),
    .i_load_val (GAP_LOAD),
    .i_en       (r_state == ST_GAP),
    .o_done     (w_gap_done)
  );

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_WAIT_RDY;
        else       w_next = ST_IDLE;
      end
      ST_WAIT_RDY: begin
        if (!fifo_wr_rst_busy) w_next = ST_WRITE;
        else                   w_next = ST_WAIT_RDY;
      end
      ST_WRITE: begin
        if (w_last_acc) begin
          if (r_cont_q && !stop) w_next = ST_GAP;
          else                   w_next = ST_IDLE;
        end else begin
          w_next = ST_WRITE;
        end
      end
      ST_GAP: begin
        if (stop)            w_next = ST_IDLE;
        else if (w_gap_done) w_next = ST_WAIT_RDY;
        else                 w_next = ST_GAP;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // state, data pattern, word/burst counters and registered status
  always_ff @(posedge clk_50M) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cont_q    <= 1'b0;
      r_word_cnt  <= CNT_W'(0);
      r_din       <= DATA_W'(0);
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_burst_cnt <= 16'd0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != ST_IDLE);
      r_done  <= w_last_acc;
      if ((r_state == ST_IDLE) && start) begin
        r_cont_q <= cont;
      end
      if (w_wr_acc) begin
        r_din <= r_din + DIN_ONE;
      end
      if (w_last_acc) begin
        r_word_cnt  <= CNT_W'(0);
        r_burst_cnt <= r_burst_cnt + 16'd1;
      end else if (w_wr_acc) begin
        r_word_cnt <= r_word_cnt + CNT_ONE;
      end
    end
  end

  assign fifo_wr_en = w_wr_acc;
  assign fifo_din   = r_din;
  assign busy       = r_busy;
  assign burst_done = r_done;
  assign burst_cnt  = r_burst_cnt;

endmodule
